// File: rtl/cpu_pkg.sv
// Shared CPU constants: flag bit positions, branch condition codes, default datapath widths.
package cpu_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVF    = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;
endpackage

// File: rtl/branch_cond.sv
// Branch condition resolver: maps a 3-bit condition code and {N,V,Z} flags to taken.
// Purely combinational, no latency, no backpressure.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);
    logic z, v, n;
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEQ:    taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~n;
            COND_LT:     taken = n;
            COND_GTE:    taken = z | ~n;
            COND_LTE:    taken = n | z;
            COND_OVF:    taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: flag register, branch resolution against registered flags, EX/MEM latch, sticky halt.
// Latency 1 cycle into the latch; mem_stall holds latch, flags and counters and suppresses redirects.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
`ifdef BRANCH_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_flush,
    input  logic              mem_stall,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        alu_flags,
    input  logic              ex_set_flags,
    input  logic              ex_is_branch,
    input  logic [2:0]        ex_cond,
    input  logic [DATA_W-1:0] ex_br_target,
    input  logic [DATA_W-1:0] ex_st_data,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_rf_we,
    input  logic              ex_mem_re,
    input  logic              ex_mem_we,
    input  logic              ex_hlt,
    output logic [2:0]        flag_reg,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_result,
    output logic [DATA_W-1:0] mem_st_data,
    output logic [REG_AW-1:0] mem_dst,
    output logic              mem_rf_we,
    output logic              mem_mem_re,
    output logic              mem_mem_we,
    output logic              halted
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0]  br_cnt_taken,
    output logic [CNT_W-1:0]  br_cnt_nt
`endif
);
    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] st_data;
        logic [REG_AW-1:0] dst;
        logic              rf_we;
        logic              mem_re;
        logic              mem_we;
    } mem_lat_t;

    mem_lat_t   lat_q, lat_d;
    logic [2:0] flag_q, flag_d;
    logic       halted_q, halted_d;
    logic       live, adv, cond_true, ctl_en;

    assign live = ex_valid & ~ex_flush & ~halted_q;
    assign adv  = live & ~mem_stall;
    // HLT travels down as a valid no-op, so its side-effect enables are dropped.
    assign ctl_en = live & ~ex_hlt;

    branch_cond u_branch_cond (
        .cond  (ex_cond),
        .flags (flag_q),
        .taken (cond_true)
    );

    assign br_taken  = adv & ex_is_branch & cond_true;
    assign br_target = ex_br_target;

    always_comb begin
        lat_d    = lat_q;
        flag_d   = flag_q;
        halted_d = halted_q;
        if (!mem_stall) begin
            lat_d.vld     = live;
            lat_d.result  = alu_result;
            lat_d.st_data = ex_st_data;
            lat_d.dst     = ex_dst;
            lat_d.rf_we   = ctl_en & ex_rf_we;
            lat_d.mem_re  = ctl_en & ex_mem_re;
            lat_d.mem_we  = ctl_en & ex_mem_we;
        end
        if (adv && ex_set_flags) flag_d = alu_flags;
        if (adv && ex_hlt)       halted_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_q    <= '0;
            flag_q   <= 3'b000;
            halted_q <= 1'b0;
        end else begin
            lat_q    <= lat_d;
            flag_q   <= flag_d;
            halted_q <= halted_d;
        end
    end

    assign flag_reg    = flag_q;
    assign halted      = halted_q;
    assign mem_valid   = lat_q.vld;
    assign mem_result  = lat_q.result;
    assign mem_st_data = lat_q.st_data;
    assign mem_dst     = lat_q.dst;
    assign mem_rf_we   = lat_q.rf_we;
    assign mem_mem_re  = lat_q.mem_re;
    assign mem_mem_we  = lat_q.mem_we;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] cnt_t_q, cnt_t_d, cnt_nt_q, cnt_nt_d;

    always_comb begin
        cnt_t_d  = cnt_t_q;
        cnt_nt_d = cnt_nt_q;
        if (adv && ex_is_branch) begin
            if (cond_true) begin
                if (cnt_t_q != '1) cnt_t_d = cnt_t_q + 1'b1;
            end else begin
                if (cnt_nt_q != '1) cnt_nt_d = cnt_nt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_t_q  <= '0;
            cnt_nt_q <= '0;
        end else begin
            cnt_t_q  <= cnt_t_d;
            cnt_nt_q <= cnt_nt_d;
        end
    end

    assign br_cnt_taken = cnt_t_q;
    assign br_cnt_nt    = cnt_nt_q;
`endif
endmodule
